// File: rtl/cluster_sleep_ctrl.sv
// Cluster sleep sequencer: gates the shared cluster clock once all enabled cores
// sleep, and restores it (holding core events) on wake. APB-configured.
//
// state     | meaning
// ACTIVE    | cluster clock running, cores free to run
// IDLE_WAIT | all enabled cores asleep, hysteresis countdown in progress
// GATED     | cluster clock gated, collecting events into pending
// RESTORE   | clock back on, settle countdown before releasing held events
module cluster_sleep_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_CORES       = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NB_CORES-1:0]       core_sleeping_i,
  input  logic [NB_CORES-1:0]       core_event_i,
  input  logic                      ext_wake_i,
  output logic [NB_CORES-1:0]       core_wake_o,
  output logic                      cluster_clk_en_o,
  output logic                      cluster_sleeping_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_GATED     = 2'd2,
    ST_RESTORE   = 2'd3
  } state_t;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_HYST     = 3'd1;
  localparam logic [2:0] IDX_WAKE_DLY = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
  localparam logic [2:0] IDX_GATE_CNT = 3'd4;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  gate_inc;

  logic                  en;
  logic [NB_CORES-1:0]   core_mask;
  logic [CNT_WIDTH-1:0]  hyst;
  logic [CNT_WIDTH-1:0]  wake_dly;
  logic [31:0]           gate_cnt;
  logic [NB_CORES-1:0]   pending;

  logic                  wr_en, rd_en;
  logic [2:0]            reg_idx;
  logic                  all_sleep, wake;
  logic                  unused_bits;

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_en   = PSEL & PENABLE & ~PWRITE;
  assign reg_idx = PADDR[4:2];
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign unused_bits = ^{PADDR, PWDATA};

  assign all_sleep = (|core_mask) & (&(core_sleeping_i | ~core_mask));
  assign wake      = (|(core_event_i & core_mask)) | ext_wake_i;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en        <= 1'b0;
      core_mask <= '1;
      hyst      <= CNT_WIDTH'(16);
      wake_dly  <= CNT_WIDTH'(4);
    end else if (wr_en) begin
      case (reg_idx)
        IDX_CTRL: begin
          en        <= PWDATA[0];
          core_mask <= PWDATA[8 +: NB_CORES];
        end
        IDX_HYST:     hyst     <= PWDATA[CNT_WIDTH-1:0];
        IDX_WAKE_DLY: wake_dly <= PWDATA[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // A clear beats a coincident increment.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      gate_cnt <= '0;
    else if (wr_en && reg_idx == IDX_GATE_CNT)
      gate_cnt <= '0;
    else if (gate_inc && gate_cnt != 32'hFFFF_FFFF)
      gate_cnt <= gate_cnt + 32'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_ACTIVE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gate_inc  = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (en && all_sleep && !wake) begin
          state_nxt = ST_IDLE_WAIT;
          cnt_nxt   = hyst;
        end
      end
      ST_IDLE_WAIT: begin
        if (!en || !all_sleep || wake) begin
          state_nxt = ST_ACTIVE;
        end else if (cnt == '0) begin
          state_nxt = ST_GATED;
          gate_inc  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_WIDTH'(1);
        end
      end
      ST_GATED: begin
        if (wake || !en) begin
          state_nxt = ST_RESTORE;
          cnt_nxt   = wake_dly;
        end
      end
      ST_RESTORE: begin
        if (cnt == '0) state_nxt = ST_ACTIVE;
        else           cnt_nxt   = cnt - CNT_WIDTH'(1);
      end
      default: state_nxt = ST_ACTIVE;
    endcase
  end

  // pending is never set in ACTIVE, so clearing every ACTIVE cycle only bites on the first.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      pending <= '0;
    else if (state == ST_ACTIVE)
      pending <= '0;
    else if (state == ST_GATED || state == ST_RESTORE)
      pending <= pending | core_event_i;
  end

  assign cluster_clk_en_o   = (state != ST_GATED);
  assign cluster_sleeping_o = (state == ST_GATED);
  assign core_wake_o = (state == ST_ACTIVE || state == ST_IDLE_WAIT) ?
                       (core_event_i | pending) : '0;

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_idx)
        IDX_CTRL: begin
          PRDATA[0]             = en;
          PRDATA[8 +: NB_CORES] = core_mask;
        end
        IDX_HYST:     PRDATA[CNT_WIDTH-1:0] = hyst;
        IDX_WAKE_DLY: PRDATA[CNT_WIDTH-1:0] = wake_dly;
        IDX_STATUS: begin
          PRDATA[1:0]           = state;
          PRDATA[2]             = cluster_clk_en_o;
          PRDATA[8 +: NB_CORES] = pending;
        end
        IDX_GATE_CNT: PRDATA = gate_cnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_sleep_ctrl.sv
// Directed bench for cluster_sleep_ctrl: gating, abort, wake/hold, masking,
// edge cases and reset-in-GATED.
module tb_cluster_sleep_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [3:0]  core_sleeping_i = '0;
  logic [3:0]  core_event_i = '0;
  logic        ext_wake_i = 1'b0;
  logic [3:0]  core_wake_o;
  logic        cluster_clk_en_o, cluster_sleeping_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] rd;

  cluster_sleep_ctrl #(.APB_ADDR_WIDTH(12), .NB_CORES(4), .CNT_WIDTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .core_sleeping_i(core_sleeping_i),
    .core_event_i(core_event_i), .ext_wake_i(ext_wake_i), .core_wake_o(core_wake_o),
    .cluster_clk_en_o(cluster_clk_en_o), .cluster_sleeping_o(cluster_sleeping_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
    @(negedge HCLK);
    PADDR = {7'd0, idx, 2'b00}; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] data);
    PADDR = {7'd0, idx, 2'b00}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    #1 data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL rst_async_clk_en got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    total_cnt++; if (cluster_sleeping_o !== 1'b0) $display("FAIL rst_sleeping got %b exp 0", cluster_sleeping_o); else pass_cnt++;
    total_cnt++; if (core_wake_o !== 4'b0) $display("FAIL rst_core_wake got %b exp 0000", core_wake_o); else pass_cnt++;
    total_cnt++; if (PRDATA !== 32'h0) $display("FAIL rst_prdata_idle got %h exp 0", PRDATA); else pass_cnt++;
    apb_read(3'd0, rd);
    total_cnt++; if (rd !== 32'h0000_0F00) $display("FAIL rst_ctrl got %h exp 00000f00", rd); else pass_cnt++;
    apb_read(3'd1, rd);
    total_cnt++; if (rd !== 32'd16) $display("FAIL rst_hyst got %0d exp 16", rd); else pass_cnt++;
    apb_read(3'd2, rd);
    total_cnt++; if (rd !== 32'd4) $display("FAIL rst_wake_dly got %0d exp 4", rd); else pass_cnt++;
    apb_read(3'd3, rd);
    total_cnt++; if (rd !== 32'h4) $display("FAIL rst_status got %h exp 4", rd); else pass_cnt++;
    apb_read(3'd4, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL rst_gate_cnt got %h exp 0", rd); else pass_cnt++;
    apb_write(3'd6, 32'hFFFF_FFFF);
    apb_read(3'd6, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL unmapped_read got %h exp 0", rd); else pass_cnt++;
  endtask

  task automatic test_gating();
    apb_write(3'd1, 32'd3);
    apb_write(3'd2, 32'd4);
    apb_write(3'd0, 32'hFFFF_FF01);
    apb_read(3'd0, rd);
    total_cnt++; if (rd !== 32'h0000_0F01) $display("FAIL ctrl_unused_bits got %h exp 00000f01", rd); else pass_cnt++;
    core_sleeping_i = 4'hF;
    repeat (4) tick();
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL gate_clk_en_cyc4 got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    tick();
    total_cnt++; if (cluster_clk_en_o !== 1'b0) $display("FAIL gate_clk_en_cyc5 got %b exp 0", cluster_clk_en_o); else pass_cnt++;
    total_cnt++; if (cluster_sleeping_o !== 1'b1) $display("FAIL gate_sleeping got %b exp 1", cluster_sleeping_o); else pass_cnt++;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd2) $display("FAIL gate_state got %0d exp 2", rd[1:0]); else pass_cnt++;
    apb_read(3'd4, rd);
    total_cnt++; if (rd !== 32'd1) $display("FAIL gate_cnt got %0d exp 1", rd); else pass_cnt++;
  endtask

  task automatic test_wake_hold();
    core_event_i = 4'b0010;
    tick();
    core_event_i = 4'b0000;
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL wake_clk_en got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd3) $display("FAIL wake_state got %0d exp 3", rd[1:0]); else pass_cnt++;
    total_cnt++; if (rd[11:8] !== 4'h2) $display("FAIL wake_pending got %h exp 2", rd[11:8]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (core_wake_o !== 4'b0) $display("FAIL restore_wake_held[%0d] got %b exp 0000", i, core_wake_o); else pass_cnt++;
      tick();
    end
    total_cnt++; if (core_wake_o !== 4'b0) $display("FAIL restore_wake_held[4] got %b exp 0000", core_wake_o); else pass_cnt++;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd3) $display("FAIL restore_len_state got %0d exp 3", rd[1:0]); else pass_cnt++;
    tick();
    total_cnt++; if (core_wake_o !== 4'b0010) $display("FAIL release_wake got %b exp 0010", core_wake_o); else pass_cnt++;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd0) $display("FAIL release_state got %0d exp 0", rd[1:0]); else pass_cnt++;
    core_sleeping_i = 4'h0;
    tick();
    total_cnt++; if (core_wake_o !== 4'b0) $display("FAIL release_one_cycle got %b exp 0000", core_wake_o); else pass_cnt++;
  endtask

  task automatic test_abort();
    apb_write(3'd4, 32'd0);
    apb_write(3'd1, 32'd10);
    core_sleeping_i = 4'hF;
    repeat (4) tick();
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd1) $display("FAIL abort_idle_state got %0d exp 1", rd[1:0]); else pass_cnt++;
    core_sleeping_i = 4'b1011;
    tick();
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd0) $display("FAIL abort_state got %0d exp 0", rd[1:0]); else pass_cnt++;
    repeat (12) tick();
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL abort_clk_en got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    apb_read(3'd4, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL abort_gate_cnt got %0d exp 0", rd); else pass_cnt++;
    core_sleeping_i = 4'h0;
  endtask

  task automatic test_mask_hyst0();
    apb_write(3'd1, 32'd0);
    apb_write(3'd0, 32'h0000_0301);
    core_sleeping_i = 4'b0011;
    tick();
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL hyst0_cyc1 got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    tick();
    total_cnt++; if (cluster_clk_en_o !== 1'b0) $display("FAIL hyst0_cyc2 got %b exp 0", cluster_clk_en_o); else pass_cnt++;
    core_event_i = 4'b1000;
    tick();
    core_event_i = 4'b0000;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd2) $display("FAIL mask_event_ignored got %0d exp 2", rd[1:0]); else pass_cnt++;
    total_cnt++; if (core_wake_o !== 4'b0) $display("FAIL mask_gated_wake got %b exp 0000", core_wake_o); else pass_cnt++;
    ext_wake_i = 1'b1;
    tick();
    ext_wake_i = 1'b0;
    core_sleeping_i = 4'h0;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd3) $display("FAIL ext_wake_state got %0d exp 3", rd[1:0]); else pass_cnt++;
    total_cnt++; if (rd[11:8] !== 4'h8) $display("FAIL ext_wake_pending got %h exp 8", rd[11:8]); else pass_cnt++;
    repeat (5) tick();
    total_cnt++; if (core_wake_o !== 4'b1000) $display("FAIL unmasked_release got %b exp 1000", core_wake_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_mask_zero();
    apb_write(3'd0, 32'h0000_0001);
    core_sleeping_i = 4'hF;
    core_event_i = 4'b0100;
    repeat (10) tick();
    total_cnt++; if (core_wake_o !== 4'b0100) $display("FAIL passthrough_wake got %b exp 0100", core_wake_o); else pass_cnt++;
    core_event_i = 4'b0000;
    apb_read(3'd3, rd);
    total_cnt++; if (rd[1:0] !== 2'd0) $display("FAIL mask0_state got %0d exp 0", rd[1:0]); else pass_cnt++;
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL mask0_clk_en got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    core_sleeping_i = 4'h0;
  endtask

  task automatic test_gate_cnt_clear();
    apb_write(3'd0, 32'h0000_0F01);
    apb_read(3'd4, rd);
    total_cnt++; if (rd !== 32'd1) $display("FAIL clr_precount got %0d exp 1", rd); else pass_cnt++;
    @(negedge HCLK);
    core_sleeping_i = 4'hF;
    PADDR = {7'd0, 3'd4, 2'b00}; PWDATA = 32'd0; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    total_cnt++; if (cluster_clk_en_o !== 1'b0) $display("FAIL clr_gated got %b exp 0", cluster_clk_en_o); else pass_cnt++;
    apb_read(3'd4, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL clr_vs_inc got %0d exp 0", rd); else pass_cnt++;
  endtask

  task automatic test_reset_gated();
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    total_cnt++; if (cluster_clk_en_o !== 1'b1) $display("FAIL rst_gated_clk_en got %b exp 1", cluster_clk_en_o); else pass_cnt++;
    total_cnt++; if (cluster_sleeping_o !== 1'b0) $display("FAIL rst_gated_sleeping got %b exp 0", cluster_sleeping_o); else pass_cnt++;
    core_sleeping_i = 4'h0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    apb_read(3'd0, rd);
    total_cnt++; if (rd !== 32'h0000_0F00) $display("FAIL post_rst_ctrl got %h exp 00000f00", rd); else pass_cnt++;
    apb_read(3'd1, rd);
    total_cnt++; if (rd !== 32'd16) $display("FAIL post_rst_hyst got %0d exp 16", rd); else pass_cnt++;
    apb_read(3'd2, rd);
    total_cnt++; if (rd !== 32'd4) $display("FAIL post_rst_wake_dly got %0d exp 4", rd); else pass_cnt++;
    apb_read(3'd3, rd);
    total_cnt++; if (rd !== 32'h4) $display("FAIL post_rst_status got %h exp 4", rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_gating();
    test_wake_hold();
    test_abort();
    test_mask_hyst0();
    test_mask_zero();
    test_gate_cnt_clear();
    test_reset_gated();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
